// File: rtl/mux_scan.sv
// mux_scan: N-way channel selector with a debounced manual select, a timed
// round-robin scan mode and a hold mode. The selected channel's data is
// registered onto out_data one cycle behind the channel index.
module mux_scan #(
    parameter int unsigned N      = 4,
    parameter int unsigned W      = 1,
    parameter int unsigned STABLE = 4,
    parameter int unsigned DWELL  = 50000000,
    localparam int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [N*W-1:0]    in_bus,
    input  logic [SELW-1:0]   sel,
    input  logic [1:0]        mode,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              chan_switch,
    output logic              sel_err
);

    // Counter widths; a one-value range still needs one bit.
    localparam int unsigned CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0]   CntMax   = CW'(STABLE - 1);
    localparam logic [CW-1:0]   CntOne   = CW'(1);
    localparam logic [DW-1:0]   DcntMax  = DW'(DWELL - 1);
    localparam logic [DW-1:0]   DcntOne  = DW'(1);
    localparam logic [SELW-1:0] ChanLast = SELW'(N - 1);
    localparam logic [SELW-1:0] ChanOne  = SELW'(1);

    typedef enum logic [1:0] {
        StManual = 2'd0,
        StScan   = 2'd1,
        StHold   = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_state_chg;

    logic [SELW-1:0] r_cand;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_dcnt;
    logic [SELW-1:0] r_out_chan;
    logic [W-1:0]    r_out_data;
    logic            r_chan_switch;
    logic            r_sel_err;

    logic [SELW-1:0] w_cand_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DW-1:0]   w_dcnt_nxt;
    logic [SELW-1:0] w_chan_nxt;
    logic            w_err_nxt;
    logic [SELW-1:0] w_chan_inc;
    logic            w_cand_oor;
    logic [W-1:0]    w_sel_data;

    // State register: follows the decoded mode pins every edge.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= StManual;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; both 10 and 11 mean hold.
    always_comb begin
        w_state_nxt = StHold;
        case (mode)
            2'b00:   w_state_nxt = StManual;
            2'b01:   w_state_nxt = StScan;
            default: w_state_nxt = StHold;
        endcase
    end

    assign w_state_chg = (w_state_nxt != r_state);

    // Wrapping channel increment for scan mode.
    assign w_chan_inc = (r_out_chan == ChanLast) ? '0 : r_out_chan + ChanOne;

    // Widened compare so a non-power-of-two N can flag unused select codes.
    assign w_cand_oor = (32'(r_cand) >= N);

    // Output/datapath next values. A mode change takes priority over any
    // commit or advance that would otherwise land on the same edge.
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        w_dcnt_nxt = r_dcnt;
        w_chan_nxt = r_out_chan;
        w_err_nxt  = r_sel_err;
        if (w_state_chg) begin
            w_err_nxt = 1'b0;
            if (w_state_nxt == StManual) begin
                w_cand_nxt = sel;
                w_cnt_nxt  = '0;
            end
            if (w_state_nxt == StScan) begin
                w_dcnt_nxt = '0;
            end
        end else begin
            case (r_state)
                StManual: begin
                    if (sel != r_cand) begin
                        // Select moved: restart the debounce on the new value.
                        w_cand_nxt = sel;
                        w_cnt_nxt  = '0;
                    end else if (r_cnt != CntMax) begin
                        w_cnt_nxt = r_cnt + CntOne;
                    end else if (w_cand_oor) begin
                        w_err_nxt = 1'b1;
                    end else if (r_cand != r_out_chan) begin
                        w_chan_nxt = r_cand;
                        w_err_nxt  = 1'b0;
                    end
                end
                StScan: begin
                    if (r_dcnt == DcntMax) begin
                        w_dcnt_nxt = '0;
                        w_chan_nxt = w_chan_inc;
                    end else begin
                        w_dcnt_nxt = r_dcnt + DcntOne;
                    end
                end
                default: begin
                    // Hold: everything frozen.
                end
            endcase
        end
    end

    // Channel data multiplexer driven by the current channel index.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (r_out_chan == SELW'(k)) begin
                w_sel_data = in_bus[k*W +: W];
            end
        end
    end

    // Datapath registers; reset discards all debounce and dwell progress.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_cand        <= '0;
            r_cnt         <= '0;
            r_dcnt        <= '0;
            r_out_chan    <= '0;
            r_out_data    <= '0;
            r_chan_switch <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            r_cand        <= w_cand_nxt;
            r_cnt         <= w_cnt_nxt;
            r_dcnt        <= w_dcnt_nxt;
            r_out_chan    <= w_chan_nxt;
            r_out_data    <= w_sel_data;
            r_chan_switch <= (w_chan_nxt != r_out_chan);
            r_sel_err     <= w_err_nxt;
        end
    end

    assign out_data    = r_out_data;
    assign out_chan    = r_out_chan;
    assign chan_switch = r_chan_switch;
    assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: two instances (N=4 and N=3) share clock and stimulus.
// A driver pushes expected outputs from a behavioural model into queues; a
// monitor pops and compares after every rising edge.
module tb_mux_scan;

    localparam int unsigned STABLE = 4;
    localparam int unsigned DWELL  = 3;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
        logic       sw;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode_s = 2'b00;
    logic [1:0]  sel_s = 2'b00;
    logic [31:0] bus = 32'hD4C3B2A1;

    logic [7:0] d0_data, d1_data;
    logic [1:0] d0_chan, d1_chan;
    logic       d0_sw, d1_sw, d0_err, d1_err;

    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    // Model state per instance: 0 = N=4, 1 = N=3.
    int         m_st[2];
    int         m_chan[2];
    int         m_prev[2];
    int         m_run[2];
    int         m_edges[2];
    logic       m_err[2];
    logic [7:0] m_data[2];
    logic       m_sw[2];

    always #5 clk = ~clk;

    mux_scan #(.N(4), .W(8), .STABLE(STABLE), .DWELL(DWELL)) dut0 (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .in_bus      (bus),
        .sel         (sel_s),
        .mode        (mode_s),
        .out_data    (d0_data),
        .out_chan    (d0_chan),
        .chan_switch (d0_sw),
        .sel_err     (d0_err)
    );

    mux_scan #(.N(3), .W(8), .STABLE(STABLE), .DWELL(DWELL)) dut1 (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .in_bus      (bus[23:0]),
        .sel         (sel_s),
        .mode        (mode_s),
        .out_data    (d1_data),
        .out_chan    (d1_chan),
        .chan_switch (d1_sw),
        .sel_err     (d1_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_st[d]    = 0;
        m_chan[d]  = 0;
        m_prev[d]  = 0;
        m_run[d]   = 1;
        m_edges[d] = 0;
        m_err[d]   = 1'b0;
        m_data[d]  = 8'h00;
        m_sw[d]    = 1'b0;
    endtask

    // Rules: a manual select commits once it has been seen on more than
    // STABLE consecutive edges; scan advances every DWELL edges after entry.
    task automatic model_step(input int d, input int n, input logic r, input logic [1:0] md,
                              input int sl, input logic [31:0] b);
        int ns;
        if (r) begin
            model_reset(d);
            return;
        end
        ns = (md == 2'b00) ? 0 : ((md == 2'b01) ? 1 : 2);
        m_data[d] = b[m_chan[d]*8 +: 8];
        m_sw[d] = 1'b0;
        if (ns != m_st[d]) begin
            m_err[d] = 1'b0;
            if (ns == 0) begin
                m_prev[d] = sl;
                m_run[d]  = 1;
            end
            if (ns == 1) m_edges[d] = 0;
        end else if (m_st[d] == 0) begin
            m_run[d] = (sl == m_prev[d]) ? m_run[d] + 1 : 1;
            if (m_run[d] > STABLE + 1) m_run[d] = STABLE + 1;
            m_prev[d] = sl;
            if (m_run[d] >= STABLE + 1) begin
                if (sl >= n) begin
                    m_err[d] = 1'b1;
                end else if (sl != m_chan[d]) begin
                    m_chan[d] = sl;
                    m_sw[d]   = 1'b1;
                    m_err[d]  = 1'b0;
                end
            end
        end else if (m_st[d] == 1) begin
            m_edges[d]++;
            if (m_edges[d] % DWELL == 0) begin
                m_chan[d] = (m_chan[d] + 1) % n;
                m_sw[d]   = 1'b1;
            end
        end
        m_st[d] = ns;
    endtask

    // One cycle: drive inputs on the falling edge, queue the expected
    // post-edge outputs, then wait for the rising edge.
    task automatic step(input logic r, input logic [1:0] md, input logic [1:0] sl,
                        input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        rst = r;
        mode_s = md;
        sel_s = sl;
        bus = b;
        mon_en = 1'b1;
        model_step(0, 4, r, md, int'(sl), b);
        model_step(1, 3, r, md, int'(sl), b);
        e.d = m_data[0]; e.c = 2'(m_chan[0]); e.sw = m_sw[0]; e.err = m_err[0];
        q0.push_back(e);
        e.d = m_data[1]; e.c = 2'(m_chan[1]); e.sw = m_sw[1]; e.err = m_err[1];
        q1.push_back(e);
        @(posedge clk);
    endtask

    task automatic steps(input int cnt, input logic [1:0] md, input logic [1:0] sl);
        for (int i = 0; i < cnt; i++) step(1'b0, md, sl, bus);
    endtask

    // Assert reset between edges and confirm outputs clear without a clock.
    task automatic reset_mid();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_data0", 32'(d0_data), 32'h0);
        chk("async_rst_chan0", 32'(d0_chan), 32'h0);
        chk("async_rst_sw0", 32'(d0_sw), 32'h0);
        chk("async_rst_err0", 32'(d0_err), 32'h0);
        chk("async_rst_chan1", 32'(d1_chan), 32'h0);
        chk("async_rst_err1", 32'(d1_err), 32'h0);
        step(1'b1, mode_s, sel_s, bus);
    endtask

    // Monitor: every rising edge, compare both instances to the queued model.
    always begin
        exp_t e0;
        exp_t e1;
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow at %0t: queue sizes %0d/%0d required >0",
                         $time, q0.size(), q1.size());
            end else begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                chk("n4_out_data", 32'(d0_data), 32'(e0.d));
                chk("n4_out_chan", 32'(d0_chan), 32'(e0.c));
                chk("n4_chan_switch", 32'(d0_sw), 32'(e0.sw));
                chk("n4_sel_err", 32'(d0_err), 32'(e0.err));
                chk("n3_out_data", 32'(d1_data), 32'(e1.d));
                chk("n3_out_chan", 32'(d1_chan), 32'(e1.c));
                chk("n3_chan_switch", 32'(d1_sw), 32'(e1.sw));
                chk("n3_sel_err", 32'(d1_err), 32'(e1.err));
            end
        end
    end

    initial begin
        logic [1:0]  md;
        logic [1:0]  sl;
        logic [31:0] b;
        int          len;
        model_reset(0);
        model_reset(1);

        // Reset, then release in manual with sel 0: out_data becomes A1.
        step(1'b1, 2'b00, 2'b00, 32'hD4C3B2A1);
        step(1'b1, 2'b00, 2'b00, 32'hD4C3B2A1);
        steps(3, 2'b00, 2'b00);

        // Manual switch to channel 2 (commit on the 5th held edge).
        steps(7, 2'b00, 2'b10);

        // Bounce: too-short holds and alternating values never commit.
        steps(3, 2'b00, 2'b00);
        steps(3, 2'b00, 2'b01);
        steps(2, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b00, (i % 2 == 0) ? 2'b10 : 2'b11, bus);

        // Range: sel 3 is valid for N=4, an error for N=3; sel 1 then clears it.
        steps(7, 2'b00, 2'b11);
        steps(7, 2'b00, 2'b01);
        steps(7, 2'b00, 2'b00);

        // Scan from channel 0, then hold, then scan again.
        steps(4, 2'b01, 2'b00);
        steps(3, 2'b10, 2'b00);
        b = bus;
        b[m_chan[0]*8 +: 8] = 8'h5A;
        step(1'b0, 2'b10, 2'b00, b);
        steps(2, 2'b11, 2'b01);
        steps(8, 2'b01, 2'b01);

        // Reset in the middle of a dwell, then release into manual.
        reset_mid();
        step(1'b1, 2'b01, 2'b00, 32'hD4C3B2A1);
        steps(3, 2'b00, 2'b00);

        // Randomised runs of mode/select/bus activity.
        md = 2'b00;
        for (int run = 0; run < 45; run++) begin
            if ($urandom_range(0, 3) == 0) md = 2'($urandom_range(0, 3));
            sl = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                b = bus;
                if ($urandom_range(0, 3) == 0) b = $urandom;
                step(1'b0, md, sl, b);
            end
            if ($urandom_range(0, 19) == 0) begin
                reset_mid();
                step(1'b0, md, sl, bus);
            end
        end

        #3;
        chk("scoreboard_drained_n4", 32'(q0.size()), 32'h0);
        chk("scoreboard_drained_n3", 32'(q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
